sting_reg_slave: RTL and testbench
==================================

Name: sting_reg_slave

Overview:
- AXI4-Lite responder that owns the sting accelerator's control/configuration register file.
- Sits between the AXI interconnect (CPU or VIP master) and the sting core datapath.
- Decodes single-beat reads and writes, holds the configuration fields as registered outputs, and reports core status and interrupt.

Parameters:
- ADDR_W, 7, AXI address width in bits; byte address, only bits [ADDR_W-1:2] decoded.
- DATA_W, 32, AXI data width in bits; fixed at 32, other values are unsupported.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous and active-low
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_W/1/1  write address channel
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write data channel
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response channel
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_W/1/1  read address channel
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read data channel
- core_busy  in  1  core running level
- core_done  in  1  one-cycle pulse at job end
- reg_soft_reset  out  1  one-cycle pulse, CTRL[0] written 1
- reg_run  out  1  CTRL[1]
- reg_div_mode, reg_bn_en, reg_lrelu_en  out  1 each  MODE[0], MODE[1], MODE[2]
- reg_axi_rd_input_xsize, reg_axi_rd_input_ysize  out  16 each  IXSIZE[15:0], IYSIZE[15:0]
- reg_axi_rd_input_start_adr, reg_axi_rd_input_fsize  out  32 each  ISADR, IFSIZE
- reg_axi_rd_weight_start_adr1, reg_axi_rd_weight_start_adr2  out  32 each  WSADR1, WSADR2
- reg_axi_rw_output_start_adr  out  32  OSADR
- reg_axi_rw_output_xsize  out  16  OXSIZE[15:0]
- reg_axi_rw_output_fsize  out  32  OFSIZE
- reg_leaky_relu  out  32  LRELU
- reg_fsize, reg_nsize  out  16 each  FNSIZE[31:16], FNSIZE[15:0]
- irq  out  1  level interrupt

Behaviour:
- Map, RW unless noted:
  - 0x00 CTRL: [0] RESET, self-clearing, reads 0; [1] RUN; [2] IRQEN.
  - 0x04 MODE, 0x08 IXSIZE, 0x0C IYSIZE, 0x10 ISADR, 0x14 IFSIZE, 0x18 WSADR1, 0x1C WSADR2, 0x20 OSADR, 0x24 OXSIZE, 0x28 OFSIZE, 0x2C LRELU, 0x30 FNSIZE.
  - 0x34 STATUS: [0] busy, RO; [1] done, sticky, W1C.
- Unimplemented bits read 0. Registers hold full written width; outputs are slices.
- Reset: every register, output, ready and valid is 0; bresp and rresp are 0.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, awready and wready are high independently until their channel is captured.
  - AW and W may arrive in either order or the same cycle.
  - The commit cycle is the cycle both are held. On that cycle the register updates on the edge, and the FSM goes to W_RESP with bvalid=1.
  - bvalid holds with stable bresp until bready; the FSM then returns to W_IDLE. Ready is re-raised the next cycle.
  - Latency: AW and W in cycle N gives bvalid at N+1; the register value is visible on the output at N+1.
- Read FSM, states R_IDLE, R_DATA:
  - arready=1 in R_IDLE. On handshake, rdata is captured from the current register state.
  - rvalid=1 the next cycle. rvalid, rdata and rresp are held until rready, then the FSM returns to R_IDLE.
  - One outstanding read and one outstanding write maximum.
- wstrb: byte lane i updates only if wstrb[i]. CTRL[0] pulses only if wstrb[0] && wdata[0].
- Unmapped address: write has no effect and bresp=SLVERR (2'b10); read returns 0 with rresp=SLVERR. Otherwise OKAY.
- Address bits [1:0] are ignored.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- done:
  - Set by core_done.
  - Cleared by a STATUS write with wdata[1]=1.
  - Set wins if both occur in the same cycle.
- irq = done & IRQEN, registered, 1-cycle latency.
- reg_soft_reset is high exactly one cycle, the cycle after commit, and does not clear other registers.
- Asynchronous reset mid-transaction aborts it; no response is issued. The FSMs restart in IDLE.

Test Plan:
- Write IXSIZE=128, IYSIZE=1024, ISADR=0x80000000, FNSIZE=0x02000300 -> xsize=128, ysize=1024, start_adr=0x80000000, fsize=0x0200, nsize=0x0300; each bresp=OKAY; read-back matches.
- W channel valid 3 cycles before AW to LRELU, data 0x12345678; bready held low 5 cycles -> bvalid stays high with OKAY, reg_leaky_relu=0x12345678 at the cycle after AW.
- OSADR=0xFFFFFFFF, then write 0x00000012 with wstrb=4'b0001 -> OSADR reads 0xFFFFFF12.
- CTRL write 0x3 -> reg_soft_reset high exactly 1 cycle, reg_run=1, CTRL reads 0x2. Read 0x3C -> rdata=0, rresp=SLVERR. Write 0x3C -> bresp=SLVERR, no register changes.
- IRQEN=1, pulse core_done -> irq=1 next cycle, STATUS=0x2. Write STATUS 0x2 coincident with a second core_done -> done stays 1. Clear again without core_done -> irq=0.
- Deassert aresetn while a read is in R_DATA with rready=0 -> rvalid=0 and all registers 0. A subsequent read of MODE returns 0 with OKAY.

Source files
------------

// File: rtl/sting_reg_slave_if.sv
// AXI4-Lite bus bundle between the interconnect master and the sting register slave.
interface sting_reg_slave_if #(
   parameter int ADDR_W = 7
) ();
   logic [ADDR_W-1:0] s_awaddr;
   logic              s_awvalid;
   logic              s_awready;
   logic [31:0]       s_wdata;
   logic [3:0]        s_wstrb;
   logic              s_wvalid;
   logic              s_wready;
   logic [1:0]        s_bresp;
   logic              s_bvalid;
   logic              s_bready;
   logic [ADDR_W-1:0] s_araddr;
   logic              s_arvalid;
   logic              s_arready;
   logic [31:0]       s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rvalid;
   logic              s_rready;

   modport slave (
      input  s_awaddr, s_awvalid, output s_awready,
      input  s_wdata, s_wstrb, s_wvalid, output s_wready,
      output s_bresp, s_bvalid, input s_bready,
      input  s_araddr, s_arvalid, output s_arready,
      output s_rdata, s_rresp, s_rvalid, input s_rready
   );

   modport master (
      output s_awaddr, s_awvalid, input s_awready,
      output s_wdata, s_wstrb, s_wvalid, input s_wready,
      input  s_bresp, s_bvalid, output s_bready,
      output s_araddr, s_arvalid, input s_arready,
      input  s_rdata, s_rresp, s_rvalid, output s_rready
   );
endinterface

// File: rtl/sting_reg_slave.sv
// AXI4-Lite register file for the sting accelerator: configuration fields,
// soft-reset pulse, sticky done status and level interrupt.
module sting_reg_slave #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   sting_reg_slave_if.slave  s,
   input  logic              core_busy,
   input  logic              core_done,
   output logic              reg_soft_reset,
   output logic              reg_run,
   output logic              reg_div_mode,
   output logic              reg_bn_en,
   output logic              reg_lrelu_en,
   output logic [15:0]       reg_axi_rd_input_xsize,
   output logic [15:0]       reg_axi_rd_input_ysize,
   output logic [31:0]       reg_axi_rd_input_start_adr,
   output logic [31:0]       reg_axi_rd_input_fsize,
   output logic [31:0]       reg_axi_rd_weight_start_adr1,
   output logic [31:0]       reg_axi_rd_weight_start_adr2,
   output logic [31:0]       reg_axi_rw_output_start_adr,
   output logic [15:0]       reg_axi_rw_output_xsize,
   output logic [31:0]       reg_axi_rw_output_fsize,
   output logic [31:0]       reg_leaky_relu,
   output logic [15:0]       reg_fsize,
   output logic [15:0]       reg_nsize,
   output logic              irq
);
   typedef enum logic { W_IDLE, W_RESP } wState_e;
   typedef enum logic { R_IDLE, R_DATA } rState_e;

   localparam int                NREG       = 13;
   localparam int                IDX_W      = ADDR_W - 2;
   localparam logic [IDX_W-1:0]  STATUS_IDX = IDX_W'(13);
   localparam logic [1:0]        RESP_OKAY  = 2'b00;
   localparam logic [1:0]        RESP_SLV   = 2'b10;

   wState_e           wStateQ, wStateD;
   rState_e           rStateQ, rStateD;
   logic              liveQ;
   logic              awCapQ, awCapD, wCapQ, wCapD;
   logic [IDX_W-1:0]  awIdxQ, awIdxD;
   logic [DATA_W-1:0] wDataQ, wDataD;
   logic [3:0]        wStrbQ, wStrbD;
   logic [1:0]        brespQ, brespD, rrespQ, rrespD;
   logic [DATA_W-1:0] rdataQ, rdataD;
   logic [DATA_W-1:0] regQ [NREG];
   logic [DATA_W-1:0] regD [NREG];
   logic              doneQ, doneD, softResetQ, softResetD, irqQ, irqD;

   logic              awHs, wHs, arHs, commit, cMapped, rdMapped;
   logic [IDX_W-1:0]  cIdx, arIdx;
   logic [DATA_W-1:0] cData, rdMux;
   logic [3:0]        cStrb;
   logic              unusedAddrBits;

   function automatic logic [DATA_W-1:0] implMask(input int idx);
      case (idx)
         0:       return DATA_W'(6);
         1:       return DATA_W'(7);
         default: return '1;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] oldV,
                                                    input logic [DATA_W-1:0] newV,
                                                    input logic [3:0]        strb);
      logic [DATA_W-1:0] v;
      v = oldV;
      for (int b = 0; b < 4; b++)
         if (strb[b]) v[8*b +: 8] = newV[8*b +: 8];
      return v;
   endfunction

   // Channels are accepted independently; a captured beat waits in its holding register.
   assign s.s_awready = liveQ && (wStateQ == W_IDLE) && !awCapQ;
   assign s.s_wready  = liveQ && (wStateQ == W_IDLE) && !wCapQ;
   assign s.s_arready = liveQ && (rStateQ == R_IDLE);
   assign s.s_bvalid  = (wStateQ == W_RESP);
   assign s.s_bresp   = brespQ;
   assign s.s_rvalid  = (rStateQ == R_DATA);
   assign s.s_rdata   = rdataQ;
   assign s.s_rresp   = rrespQ;

   assign awHs    = s.s_awvalid && s.s_awready;
   assign wHs     = s.s_wvalid && s.s_wready;
   assign arHs    = s.s_arvalid && s.s_arready;
   assign cIdx    = awCapQ ? awIdxQ : s.s_awaddr[ADDR_W-1:2];
   assign cData   = wCapQ ? wDataQ : s.s_wdata;
   assign cStrb   = wCapQ ? wStrbQ : s.s_wstrb;
   assign commit  = (wStateQ == W_IDLE) && (awCapQ || awHs) && (wCapQ || wHs);
   assign cMapped = (cIdx <= STATUS_IDX);
   assign arIdx   = s.s_araddr[ADDR_W-1:2];
   assign unusedAddrBits = ^{s.s_awaddr[1:0], s.s_araddr[1:0]};

   // Write channel FSM: collect AW and W in any order, then hold the response.
   always_comb begin
      wStateD = wStateQ;
      awCapD  = awCapQ;
      awIdxD  = awIdxQ;
      wCapD   = wCapQ;
      wDataD  = wDataQ;
      wStrbD  = wStrbQ;
      brespD  = brespQ;
      if (awHs) begin
         awCapD = 1'b1;
         awIdxD = s.s_awaddr[ADDR_W-1:2];
      end
      if (wHs) begin
         wCapD  = 1'b1;
         wDataD = s.s_wdata;
         wStrbD = s.s_wstrb;
      end
      case (wStateQ)
         W_IDLE: if (commit) begin
            wStateD = W_RESP;
            awCapD  = 1'b0;
            wCapD   = 1'b0;
            brespD  = cMapped ? RESP_OKAY : RESP_SLV;
         end
         W_RESP: if (s.s_bready) wStateD = W_IDLE;
         default: wStateD = W_IDLE;
      endcase
   end

   // Register file update; a core_done pulse beats a simultaneous W1C of done.
   always_comb begin
      for (int i = 0; i < NREG; i++) regD[i] = regQ[i];
      softResetD = 1'b0;
      doneD      = doneQ;
      if (commit) begin
         for (int i = 0; i < NREG; i++)
            if (cIdx == IDX_W'(i)) regD[i] = mergeBytes(regQ[i], cData, cStrb) & implMask(i);
         if (cIdx == '0) softResetD = cStrb[0] && cData[0];
         if (cIdx == STATUS_IDX && cStrb[0] && cData[1]) doneD = 1'b0;
      end
      if (core_done) doneD = 1'b1;
      irqD = doneD && regD[0][2];
   end

   // Read path samples the pre-write register state at the AR handshake.
   always_comb begin
      rdMux    = '0;
      rdMapped = 1'b1;
      for (int i = 0; i < NREG; i++)
         if (arIdx == IDX_W'(i)) rdMux = regQ[i];
      if (arIdx == STATUS_IDX) rdMux = {{(DATA_W-2){1'b0}}, doneQ, core_busy};
      else if (arIdx > STATUS_IDX) rdMapped = 1'b0;
   end

   always_comb begin
      rStateD = rStateQ;
      rdataD  = rdataQ;
      rrespD  = rrespQ;
      case (rStateQ)
         R_IDLE: if (arHs) begin
            rStateD = R_DATA;
            rdataD  = rdMux;
            rrespD  = rdMapped ? RESP_OKAY : RESP_SLV;
         end
         R_DATA: if (s.s_rready) rStateD = R_IDLE;
         default: rStateD = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wStateQ    <= W_IDLE;
         rStateQ    <= R_IDLE;
         liveQ      <= 1'b0;
         awCapQ     <= 1'b0;
         wCapQ      <= 1'b0;
         awIdxQ     <= '0;
         wDataQ     <= '0;
         wStrbQ     <= '0;
         brespQ     <= '0;
         rrespQ     <= '0;
         rdataQ     <= '0;
         doneQ      <= 1'b0;
         softResetQ <= 1'b0;
         irqQ       <= 1'b0;
         for (int i = 0; i < NREG; i++) regQ[i] <= '0;
      end else begin
         wStateQ    <= wStateD;
         rStateQ    <= rStateD;
         liveQ      <= 1'b1;
         awCapQ     <= awCapD;
         wCapQ      <= wCapD;
         awIdxQ     <= awIdxD;
         wDataQ     <= wDataD;
         wStrbQ     <= wStrbD;
         brespQ     <= brespD;
         rrespQ     <= rrespD;
         rdataQ     <= rdataD;
         doneQ      <= doneD;
         softResetQ <= softResetD;
         irqQ       <= irqD;
         for (int i = 0; i < NREG; i++) regQ[i] <= regD[i];
      end
   end

   assign reg_soft_reset               = softResetQ;
   assign reg_run                      = regQ[0][1];
   assign reg_div_mode                 = regQ[1][0];
   assign reg_bn_en                    = regQ[1][1];
   assign reg_lrelu_en                 = regQ[1][2];
   assign reg_axi_rd_input_xsize       = regQ[2][15:0];
   assign reg_axi_rd_input_ysize       = regQ[3][15:0];
   assign reg_axi_rd_input_start_adr   = regQ[4];
   assign reg_axi_rd_input_fsize       = regQ[5];
   assign reg_axi_rd_weight_start_adr1 = regQ[6];
   assign reg_axi_rd_weight_start_adr2 = regQ[7];
   assign reg_axi_rw_output_start_adr  = regQ[8];
   assign reg_axi_rw_output_xsize      = regQ[9][15:0];
   assign reg_axi_rw_output_fsize      = regQ[10];
   assign reg_leaky_relu               = regQ[11];
   assign reg_fsize                    = regQ[12][31:16];
   assign reg_nsize                    = regQ[12][15:0];
   assign irq                          = irqQ;
endmodule

// File: tb/tb_sting_reg_slave.sv
// Scoreboard bench for sting_reg_slave: directed register scenarios plus
// randomized traffic against a simple address-map model.
module tb_sting_reg_slave;
   localparam int TIMEOUT = 50;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        core_busy, core_done;
   logic        reg_soft_reset, reg_run, reg_div_mode, reg_bn_en, reg_lrelu_en;
   logic [15:0] reg_axi_rd_input_xsize, reg_axi_rd_input_ysize;
   logic [31:0] reg_axi_rd_input_start_adr, reg_axi_rd_input_fsize;
   logic [31:0] reg_axi_rd_weight_start_adr1, reg_axi_rd_weight_start_adr2;
   logic [31:0] reg_axi_rw_output_start_adr;
   logic [15:0] reg_axi_rw_output_xsize;
   logic [31:0] reg_axi_rw_output_fsize, reg_leaky_relu;
   logic [15:0] reg_fsize, reg_nsize;
   logic        irq;

   always #5 aclk = ~aclk;

   sting_reg_slave_if #(.ADDR_W(7)) bus ();

   sting_reg_slave #(.ADDR_W(7), .DATA_W(32)) dut (
      .aclk(aclk), .aresetn(aresetn), .s(bus),
      .core_busy(core_busy), .core_done(core_done),
      .reg_soft_reset(reg_soft_reset), .reg_run(reg_run),
      .reg_div_mode(reg_div_mode), .reg_bn_en(reg_bn_en), .reg_lrelu_en(reg_lrelu_en),
      .reg_axi_rd_input_xsize(reg_axi_rd_input_xsize),
      .reg_axi_rd_input_ysize(reg_axi_rd_input_ysize),
      .reg_axi_rd_input_start_adr(reg_axi_rd_input_start_adr),
      .reg_axi_rd_input_fsize(reg_axi_rd_input_fsize),
      .reg_axi_rd_weight_start_adr1(reg_axi_rd_weight_start_adr1),
      .reg_axi_rd_weight_start_adr2(reg_axi_rd_weight_start_adr2),
      .reg_axi_rw_output_start_adr(reg_axi_rw_output_start_adr),
      .reg_axi_rw_output_xsize(reg_axi_rw_output_xsize),
      .reg_axi_rw_output_fsize(reg_axi_rw_output_fsize),
      .reg_leaky_relu(reg_leaky_relu),
      .reg_fsize(reg_fsize), .reg_nsize(reg_nsize),
      .irq(irq)
   );

   int          checks = 0;
   int          errors = 0;
   logic [1:0]  bExpQ [$];
   logic [33:0] rExpQ [$];
   logic [31:0] modelReg [13];
   bit          modelDone;
   int          expPulses = 0;
   int          seenPulses = 0;
   bit          pulseDoneAtCommit = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic void modelReset();
      for (int i = 0; i < 13; i++) modelReg[i] = '0;
      modelDone = 1'b0;
   endfunction

   // Address map model: word index = addr/4, CTRL keeps RUN/IRQEN, MODE keeps 3 bits.
   function automatic void modelWrite(input logic [6:0] a, input logic [31:0] d, input logic [3:0] strb);
      int idx;
      logic [31:0] v;
      idx = int'(a[6:2]);
      if (idx < 13) begin
         v = modelReg[idx];
         for (int b = 0; b < 4; b++)
            if (strb[b]) v[8*b +: 8] = d[8*b +: 8];
         if (idx == 0) v = v & 32'h6;
         if (idx == 1) v = v & 32'h7;
         modelReg[idx] = v;
         if (idx == 0 && strb[0] && d[0]) expPulses++;
      end else if (idx == 13) begin
         if (strb[0] && d[1]) modelDone = 1'b0;
      end
   endfunction

   function automatic void modelRead(input logic [6:0] a, output logic [31:0] d, output logic [1:0] r);
      int idx;
      idx = int'(a[6:2]);
      r = 2'b00;
      if (idx < 13) d = modelReg[idx];
      else if (idx == 13) d = {30'b0, modelDone, core_busy};
      else begin
         d = '0;
         r = 2'b10;
      end
   endfunction

   task automatic checkAllOutputs(input string tag, input bit expSoft);
      checkOutput({tag, ":soft_reset"}, 32'(reg_soft_reset), 32'(expSoft));
      checkOutput({tag, ":run"}, 32'(reg_run), 32'(modelReg[0][1]));
      checkOutput({tag, ":mode"}, {29'b0, reg_lrelu_en, reg_bn_en, reg_div_mode}, modelReg[1]);
      checkOutput({tag, ":ixsize"}, 32'(reg_axi_rd_input_xsize), 32'(modelReg[2][15:0]));
      checkOutput({tag, ":iysize"}, 32'(reg_axi_rd_input_ysize), 32'(modelReg[3][15:0]));
      checkOutput({tag, ":isadr"}, reg_axi_rd_input_start_adr, modelReg[4]);
      checkOutput({tag, ":ifsize"}, reg_axi_rd_input_fsize, modelReg[5]);
      checkOutput({tag, ":wsadr1"}, reg_axi_rd_weight_start_adr1, modelReg[6]);
      checkOutput({tag, ":wsadr2"}, reg_axi_rd_weight_start_adr2, modelReg[7]);
      checkOutput({tag, ":osadr"}, reg_axi_rw_output_start_adr, modelReg[8]);
      checkOutput({tag, ":oxsize"}, 32'(reg_axi_rw_output_xsize), 32'(modelReg[9][15:0]));
      checkOutput({tag, ":ofsize"}, reg_axi_rw_output_fsize, modelReg[10]);
      checkOutput({tag, ":lrelu"}, reg_leaky_relu, modelReg[11]);
      checkOutput({tag, ":fnsize"}, {reg_fsize, reg_nsize}, modelReg[12]);
      checkOutput({tag, ":irq"}, 32'(irq), 32'(modelDone && modelReg[0][2]));
   endtask

   // Monitor: every completed B or R handshake is matched against the next queued expectation.
   always @(negedge aclk) begin
      logic [1:0]  eb;
      logic [33:0] er;
      if (reg_soft_reset) seenPulses++;
      if (bus.s_bvalid && bus.s_bready) begin
         checks++;
         if (bExpQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL bresp-sb: got response %0d, expected none queued", bus.s_bresp);
         end else begin
            eb = bExpQ.pop_front();
            if (bus.s_bresp !== eb) begin
               errors++;
               $display("[TB] FAIL bresp-sb: got %0d, expected %0d", bus.s_bresp, eb);
            end
         end
      end
      if (bus.s_rvalid && bus.s_rready) begin
         checks++;
         if (rExpQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL rdata-sb: got 0x%08h, expected none queued", bus.s_rdata);
         end else begin
            er = rExpQ.pop_front();
            if ({bus.s_rresp, bus.s_rdata} !== er) begin
               errors++;
               $display("[TB] FAIL rdata-sb: got resp %0d data 0x%08h, expected resp %0d data 0x%08h",
                        bus.s_rresp, bus.s_rdata, er[33:32], er[31:0]);
            end
         end
      end
   end

   task automatic axiWrite(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bDelay);
      logic [1:0] expResp;
      bit awDone, wDone, awHs, wHs, hs, expSoft;
      int cyc;
      expResp = (addr[6:2] <= 5'd13) ? 2'b00 : 2'b10;
      expSoft = (addr[6:2] == 5'd0) && strb[0] && data[0];
      modelWrite(addr, data, strb);
      if (pulseDoneAtCommit) modelDone = 1'b1;
      bExpQ.push_back(expResp);
      bus.s_awaddr  = addr;
      bus.s_wdata   = data;
      bus.s_wstrb   = strb;
      bus.s_wvalid  = 1'b1;
      bus.s_awvalid = (lead == 0);
      bus.s_bready  = 1'b0;
      core_done     = pulseDoneAtCommit;
      awDone = 1'b0;
      wDone  = 1'b0;
      cyc    = 0;
      while (!(awDone && wDone)) begin
         @(negedge aclk);
         awHs = bus.s_awvalid && bus.s_awready;
         wHs  = bus.s_wvalid && bus.s_wready;
         @(posedge aclk);
         #1;
         core_done = 1'b0;
         if (awHs) begin
            awDone = 1'b1;
            bus.s_awvalid = 1'b0;
         end
         if (wHs) begin
            wDone = 1'b1;
            bus.s_wvalid = 1'b0;
         end
         cyc++;
         if (!awDone && cyc >= lead) bus.s_awvalid = 1'b1;
         if (!(awDone && wDone) && cyc > TIMEOUT) begin
            checks++;
            errors++;
            $display("[TB] FAIL aw-w-handshake: got no accept after %0d cycles, expected accept", cyc);
            bus.s_awvalid = 1'b0;
            bus.s_wvalid  = 1'b0;
            return;
         end
      end
      checkOutput("bvalid-latency", 32'(bus.s_bvalid), 32'd1);
      checkAllOutputs("commit", expSoft);
      for (int i = 0; i < bDelay; i++) begin
         @(posedge aclk);
         #1;
         checkOutput("bvalid-hold", 32'(bus.s_bvalid), 32'd1);
         checkOutput("bresp-hold", 32'(bus.s_bresp), 32'(expResp));
      end
      bus.s_bready = 1'b1;
      cyc = 0;
      hs  = 1'b0;
      while (!hs) begin
         @(negedge aclk);
         hs = bus.s_bvalid && bus.s_bready;
         @(posedge aclk);
         #1;
         cyc++;
         if (!hs && cyc > TIMEOUT) begin
            checks++;
            errors++;
            $display("[TB] FAIL b-handshake: got no bvalid after %0d cycles, expected bvalid", cyc);
            break;
         end
      end
      bus.s_bready = 1'b0;
      checkAllOutputs("write-done", 1'b0);
      checkOutput("soft-pulse-count", 32'(seenPulses), 32'(expPulses));
   endtask

   task automatic axiRead(input logic [6:0] addr, input int rDelay);
      logic [31:0] d;
      logic [1:0]  r;
      bit hs;
      int cyc;
      modelRead(addr, d, r);
      rExpQ.push_back({r, d});
      bus.s_araddr  = addr;
      bus.s_arvalid = 1'b1;
      bus.s_rready  = 1'b0;
      cyc = 0;
      hs  = 1'b0;
      while (!hs) begin
         @(negedge aclk);
         hs = bus.s_arvalid && bus.s_arready;
         @(posedge aclk);
         #1;
         cyc++;
         if (!hs && cyc > TIMEOUT) begin
            checks++;
            errors++;
            $display("[TB] FAIL ar-handshake: got no arready after %0d cycles, expected arready", cyc);
            bus.s_arvalid = 1'b0;
            return;
         end
      end
      bus.s_arvalid = 1'b0;
      checkOutput("rvalid-latency", 32'(bus.s_rvalid), 32'd1);
      for (int i = 0; i < rDelay; i++) begin
         @(posedge aclk);
         #1;
         checkOutput("rvalid-hold", 32'(bus.s_rvalid), 32'd1);
         checkOutput("rdata-hold", bus.s_rdata, d);
      end
      bus.s_rready = 1'b1;
      cyc = 0;
      hs  = 1'b0;
      while (!hs) begin
         @(negedge aclk);
         hs = bus.s_rvalid && bus.s_rready;
         @(posedge aclk);
         #1;
         cyc++;
         if (!hs && cyc > TIMEOUT) begin
            checks++;
            errors++;
            $display("[TB] FAIL r-handshake: got no rvalid after %0d cycles, expected rvalid", cyc);
            break;
         end
      end
      bus.s_rready = 1'b0;
   endtask

   // Random reads and writes over mapped, STATUS and unmapped words with random byte offsets.
   task automatic applyStimulus(input int n);
      logic [6:0] a;
      for (int t = 0; t < n; t++) begin
         a = 7'(($urandom_range(0, 20) << 2) | $urandom_range(0, 3));
         core_busy = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1)
            axiWrite(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)));
         else
            axiRead(a, int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish by 500us, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pulsesBefore;
      aresetn = 1'b0;
      core_busy = 1'b0;
      core_done = 1'b0;
      bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
      bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
      bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
      modelReset();
      repeat (3) @(posedge aclk);
      #1;
      checkAllOutputs("reset", 1'b0);
      checkOutput("reset:readys", {29'b0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'd0);
      checkOutput("reset:valids", {28'b0, bus.s_bresp != 2'b00, bus.s_rresp != 2'b00, bus.s_bvalid, bus.s_rvalid}, 32'd0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;

      axiWrite(7'h08, 32'd128, 4'hF, 0, 0);
      axiWrite(7'h0C, 32'd1024, 4'hF, 0, 0);
      axiWrite(7'h10, 32'h8000_0000, 4'hF, 0, 0);
      axiWrite(7'h30, 32'h0200_0300, 4'hF, 0, 0);
      checkOutput("xsize", 32'(reg_axi_rd_input_xsize), 32'd128);
      checkOutput("ysize", 32'(reg_axi_rd_input_ysize), 32'd1024);
      checkOutput("start_adr", reg_axi_rd_input_start_adr, 32'h8000_0000);
      checkOutput("fsize", 32'(reg_fsize), 32'h0200);
      checkOutput("nsize", 32'(reg_nsize), 32'h0300);
      axiRead(7'h08, 0);
      axiRead(7'h0C, 1);
      axiRead(7'h10, 0);
      axiRead(7'h30, 2);

      axiWrite(7'h2C, 32'h1234_5678, 4'hF, 3, 5);
      checkOutput("lrelu", reg_leaky_relu, 32'h1234_5678);

      axiWrite(7'h20, 32'hFFFF_FFFF, 4'hF, 0, 0);
      axiWrite(7'h21, 32'h0000_0012, 4'h1, 1, 0);
      checkOutput("osadr-strb", reg_axi_rw_output_start_adr, 32'hFFFF_FF12);
      axiRead(7'h20, 0);

      pulsesBefore = seenPulses;
      axiWrite(7'h00, 32'h3, 4'hF, 0, 2);
      checkOutput("soft-reset-once", 32'(seenPulses - pulsesBefore), 32'd1);
      checkOutput("run", 32'(reg_run), 32'd1);
      axiRead(7'h00, 0);
      axiRead(7'h3C, 1);
      axiWrite(7'h3C, 32'hDEAD_BEEF, 4'hF, 0, 1);

      axiWrite(7'h00, 32'h6, 4'hF, 0, 0);
      core_done = 1'b1;
      @(posedge aclk);
      #1;
      core_done = 1'b0;
      modelDone = 1'b1;
      checkOutput("irq-after-done", 32'(irq), 32'd1);
      axiRead(7'h34, 0);
      pulseDoneAtCommit = 1'b1;
      axiWrite(7'h34, 32'h2, 4'hF, 0, 0);
      pulseDoneAtCommit = 1'b0;
      checkOutput("irq-set-wins", 32'(irq), 32'd1);
      axiRead(7'h34, 0);
      axiWrite(7'h34, 32'h2, 4'hF, 0, 0);
      checkOutput("irq-cleared", 32'(irq), 32'd0);
      axiRead(7'h34, 0);

      applyStimulus(40);
      core_busy = 1'b0;

      axiWrite(7'h04, 32'h5, 4'hF, 0, 0);
      bus.s_araddr  = 7'h04;
      bus.s_arvalid = 1'b1;
      bus.s_rready  = 1'b0;
      @(posedge aclk);
      #1;
      bus.s_arvalid = 1'b0;
      checkOutput("abort:rvalid-before", 32'(bus.s_rvalid), 32'd1);
      @(posedge aclk);
      #3;
      aresetn = 1'b0;
      #1;
      modelReset();
      checkOutput("abort:rvalid", 32'(bus.s_rvalid), 32'd0);
      checkAllOutputs("abort", 1'b0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      axiRead(7'h04, 0);
      repeat (2) @(posedge aclk);
      #1;

      checkOutput("sb-b-empty", 32'(bExpQ.size()), 32'd0);
      checkOutput("sb-r-empty", 32'(rExpQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
